move_input_conditioner: RTL and testbench

Conditions the raw direction and start push-buttons into clean, single-cycle movement commands for the Frogger game core. Each button is synchronised, debounced and edge-detected. A four-state FSM then arbitrates simultaneous presses and generates hold-to-repeat moves. The block sits between the board switch pins and the game top level, and drives its `i_Up_Mvt`, `i_Down_Mvt`, `i_Left_Mvt`, `i_Right_Mvt` and `i_Game_Start` inputs.

---
 rtl/move_input_conditioner_pkg.sv | 32 +++
 rtl/move_input_conditioner_debounce_filter.sv | 42 ++++
 rtl/move_input_conditioner.sv | 121 ++++++++++++
 tb/tb_move_input_conditioner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/move_input_conditioner_pkg.sv
// rtl/move_input_conditioner_pkg.sv - direction indices, FSM states, timing defaults and arbiter helper
package move_input_conditioner_pkg;

   localparam int DIR_UP    = 3;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_LEFT  = 1;
   localparam int DIR_RIGHT = 0;

   // 25 MHz pixel clock: 10 ms debounce, 500 ms first repeat, 200 ms repeat period.
   localparam int DEF_DEBOUNCE_LIMIT = 250000;
   localparam int DEF_REPEAT_DELAY   = 12500000;
   localparam int DEF_REPEAT_PERIOD  = 5000000;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_HELD         = 2'd1,
      ST_REPEAT       = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } mvt_state_e;

   // One-hot grant of the highest-priority rise (Up > Down > Left > Right); losers are dropped.
   function automatic logic [3:0] pick_direction(input logic [3:0] rise);
      logic [3:0] grant;
      grant = 4'b0000;
      if (rise[DIR_UP])         grant[DIR_UP]    = 1'b1;
      else if (rise[DIR_DOWN])  grant[DIR_DOWN]  = 1'b1;
      else if (rise[DIR_LEFT])  grant[DIR_LEFT]  = 1'b1;
      else if (rise[DIR_RIGHT]) grant[DIR_RIGHT] = 1'b1;
      return grant;
   endfunction

endpackage

// File: rtl/move_input_conditioner_debounce_filter.sv
// rtl/move_input_conditioner_debounce_filter.sv - 2-flop synchroniser plus stable-count debounce
module move_input_conditioner_debounce_filter
   import move_input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level
);

   localparam int               CNT_W  = $clog2(DEBOUNCE_LIMIT) + 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_LIMIT - 1);

   logic             sync_a;
   logic             sync_b;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         cnt    <= '0;
         level  <= 1'b0;
      end else begin
         sync_a <= btn;
         sync_b <= sync_a;
         // Any cycle that agrees with the accepted level restarts the stability count.
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == CNT_TC) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/move_input_conditioner.sv
// rtl/move_input_conditioner.sv - debounced buttons to single-cycle, arbitrated, auto-repeating move pulses
module move_input_conditioner
   import move_input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
   parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
)
(
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Btn_Up,
   input  logic       i_Btn_Down,
   input  logic       i_Btn_Left,
   input  logic       i_Btn_Right,
   input  logic       i_Btn_Start,
   input  logic       i_Freeze,
   output logic       o_Up_Mvt,
   output logic       o_Down_Mvt,
   output logic       o_Left_Mvt,
   output logic       o_Right_Mvt,
   output logic       o_Game_Start,
   output logic [3:0] o_Dir_Held
);

   localparam int               RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int               RPT_W     = $clog2(RPT_MAX) + 1;
   localparam logic [RPT_W-1:0] DELAY_TC  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_TC = RPT_W'(REPEAT_PERIOD - 1);

   logic [4:0]       btn_raw;
   logic [4:0]       level;
   logic [4:0]       level_prev;
   logic [4:0]       rise;
   logic [3:0]       winner;
   logic [3:0]       active;
   logic [3:0]       mvt;
   logic             active_held;
   logic [RPT_W-1:0] rpt_cnt;
   logic [RPT_W-1:0] rpt_tc;
   mvt_state_e       state;

   // Bit 4 is Start; bits 3:0 follow the direction indices.
   assign btn_raw = {i_Btn_Start, i_Btn_Up, i_Btn_Down, i_Btn_Left, i_Btn_Right};

   for (genvar g = 0; g < 5; g++) begin : g_filter
      move_input_conditioner_debounce_filter #(
         .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
      ) u_filter (
         .clk   (i_Clk),
         .rst_n (i_Rst_L),
         .btn   (btn_raw[g]),
         .level (level[g])
      );
   end

   assign rise        = level & ~level_prev;
   assign winner      = pick_direction(rise[3:0]);
   assign active_held = |(level[3:0] & active);
   assign rpt_tc      = (state == ST_HELD) ? DELAY_TC : PERIOD_TC;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         level_prev   <= '0;
         o_Game_Start <= 1'b0;
      end else begin
         level_prev   <= level;
         o_Game_Start <= rise[4];
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state   <= ST_IDLE;
         active  <= '0;
         mvt     <= '0;
         rpt_cnt <= '0;
      end else begin
         mvt <= '0;
         case (state)
            ST_IDLE: begin
               if (!i_Freeze && (|rise[3:0])) begin
                  active  <= winner;
                  mvt     <= winner;
                  rpt_cnt <= '0;
                  state   <= ST_HELD;
               end
            end
            ST_HELD, ST_REPEAT: begin
               // Release outranks both freeze and a repeat falling due on the same edge.
               if (!active_held) begin
                  state <= ST_IDLE;
               end else if (i_Freeze) begin
                  state <= ST_WAIT_RELEASE;
               end else if (REPEAT_PERIOD != 0) begin
                  if (rpt_cnt == rpt_tc) begin
                     mvt     <= active;
                     rpt_cnt <= '0;
                     state   <= ST_REPEAT;
                  end else begin
                     rpt_cnt <= rpt_cnt + 1'b1;
                  end
               end
            end
            ST_WAIT_RELEASE: begin
               if (!active_held && !i_Freeze) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_Up_Mvt    = mvt[DIR_UP];
   assign o_Down_Mvt  = mvt[DIR_DOWN];
   assign o_Left_Mvt  = mvt[DIR_LEFT];
   assign o_Right_Mvt = mvt[DIR_RIGHT];
   assign o_Dir_Held  = level[3:0];

endmodule

// File: tb/tb_move_input_conditioner.sv
// tb/tb_move_input_conditioner.sv - scoreboard bench against a window/deadline reference model
module tb_move_input_conditioner;

   localparam int LIM  = 4;
   localparam int DLY  = 10;
   localparam int PER  = 5;
   localparam int MAXE = 8192;

   typedef struct {
      int         edge_n;
      logic [3:0] mvt;
      logic       start;
      logic [3:0] held;
   } exp_t;

   logic       clk = 1'b0;
   logic       i_Rst_L = 1'b0;
   logic       i_Btn_Up = 1'b0, i_Btn_Down = 1'b0, i_Btn_Left = 1'b0, i_Btn_Right = 1'b0;
   logic       i_Btn_Start = 1'b0, i_Freeze = 1'b0;
   logic       o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt, o_Game_Start;
   logic [3:0] o_Dir_Held;

   int   cyc = 0;
   int   tests = 0;
   int   failed = 0;
   bit   started = 0;
   bit   done = 0;
   exp_t sb_q[$];

   // Reference model state: raw samples per edge, debounced levels, and the move tracker.
   bit       hist [0:4][0:MAXE-1];
   int       base = 1;
   bit [4:0] m_lvl = '0;
   bit [4:0] m_prev = '0;
   int       m_active = -1;
   bit       m_wait = 0;
   int       m_due = 0;
   bit       rst_was = 0;

   move_input_conditioner #(
      .DEBOUNCE_LIMIT(LIM),
      .REPEAT_DELAY  (DLY),
      .REPEAT_PERIOD (PER)
   ) dut (
      .i_Clk       (clk),
      .i_Rst_L     (i_Rst_L),
      .i_Btn_Up    (i_Btn_Up),
      .i_Btn_Down  (i_Btn_Down),
      .i_Btn_Left  (i_Btn_Left),
      .i_Btn_Right (i_Btn_Right),
      .i_Btn_Start (i_Btn_Start),
      .i_Freeze    (i_Freeze),
      .o_Up_Mvt    (o_Up_Mvt),
      .o_Down_Mvt  (o_Down_Mvt),
      .o_Left_Mvt  (o_Left_Mvt),
      .o_Right_Mvt (o_Right_Mvt),
      .o_Game_Start(o_Game_Start),
      .o_Dir_Held  (o_Dir_Held)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit smp(int b, int k);
      if (k < base) return 1'b0;
      return hist[b][k % MAXE];
   endfunction

   // A level is accepted once the last LIM synchronised samples all disagree with it.
   task automatic step(input logic [4:0] raw, input logic frz, input logic rst);
      int       e;
      exp_t     x;
      bit [4:0] rise;
      bit [4:0] nl;
      bit       all_diff;
      @(negedge clk);
      {i_Btn_Start, i_Btn_Up, i_Btn_Down, i_Btn_Left, i_Btn_Right} = raw;
      i_Freeze = frz;
      i_Rst_L  = rst;
      e = cyc + 1;
      x.edge_n = e;
      x.mvt    = '0;
      x.start  = 1'b0;
      x.held   = '0;
      if (!rst) begin
         m_lvl = '0; m_prev = '0; m_active = -1; m_wait = 0; base = e + 1;
      end else begin
         for (int b = 0; b < 5; b++) hist[b][e % MAXE] = raw[b];
         rise    = m_lvl & ~m_prev;
         x.start = rise[4];
         if (m_active < 0) begin
            if (!frz && (|rise[3:0])) begin
               for (int d = 3; d >= 0; d--) begin
                  if (rise[d] && m_active < 0) m_active = d;
               end
               x.mvt[m_active] = 1'b1;
               m_wait = 0;
               m_due  = e + DLY;
            end
         end else if (m_wait) begin
            if (!m_lvl[m_active] && !frz) m_active = -1;
         end else if (!m_lvl[m_active]) begin
            m_active = -1;
         end else if (frz) begin
            m_wait = 1;
         end else if (e == m_due) begin
            x.mvt[m_active] = 1'b1;
            m_due = e + PER;
         end
         for (int b = 0; b < 5; b++) begin
            all_diff = 1'b1;
            for (int k = e - LIM - 1; k <= e - 2; k++) begin
               if (smp(b, k) == m_lvl[b]) all_diff = 1'b0;
            end
            nl[b] = all_diff ? ~m_lvl[b] : m_lvl[b];
         end
         m_prev = m_lvl;
         m_lvl  = nl;
         x.held = m_lvl[3:0];
      end
      sb_q.push_back(x);
      started = 1;
      if (!rst && rst_was) begin
         #1;
         tests++;
         if ({o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt, o_Game_Start, o_Dir_Held} !== 9'd0) begin
            failed++;
            $display("FAIL async_reset_clear: outputs=%b required=000000000",
                     {o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt, o_Game_Start, o_Dir_Held});
         end
      end
      rst_was = rst;
   endtask

   task automatic hold(input logic [4:0] raw, input logic frz, input int n);
      for (int i = 0; i < n; i++) step(raw, frz, 1'b1);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (started && !done) begin
            tests++;
            if (sb_q.size() == 0) begin
               failed++;
               $display("FAIL scoreboard_underflow: edge=%0d has no expected entry", cyc);
            end else begin
               x = sb_q.pop_front();
               if (x.edge_n != cyc ||
                   {o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt} !== x.mvt ||
                   o_Game_Start !== x.start || o_Dir_Held !== x.held) begin
                  failed++;
                  $display("FAIL outputs edge=%0d: mvt=%b start=%b held=%b required edge=%0d mvt=%b start=%b held=%b",
                           cyc, {o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt}, o_Game_Start, o_Dir_Held,
                           x.edge_n, x.mvt, x.start, x.held);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #(400000 * 10);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      logic [4:0] r;
      logic       f;
      int         flip;
      // raw bit order: {Start, Up, Down, Left, Right}
      for (int i = 0; i < 3; i++) step(5'b00000, 1'b0, 1'b0);
      hold(5'b00000, 1'b0, 2);
      hold(5'b01000, 1'b0, 8);
      hold(5'b00000, 1'b0, 8);
      for (int i = 0; i < 20; i++) step((i % 4) < 2 ? 5'b00010 : 5'b00000, 1'b0, 1'b1);
      hold(5'b00000, 1'b0, 8);
      hold(5'b00001, 1'b0, 40);
      hold(5'b00000, 1'b0, 10);
      hold(5'b00110, 1'b0, 20);
      hold(5'b00010, 1'b0, 10);
      hold(5'b00000, 1'b0, 10);
      hold(5'b01000, 1'b0, 12);
      hold(5'b01000, 1'b1, 3);
      hold(5'b01000, 1'b0, 10);
      hold(5'b00000, 1'b0, 10);
      hold(5'b01000, 1'b0, 10);
      hold(5'b00000, 1'b0, 10);
      hold(5'b00001, 1'b0, 25);
      step(5'b00001, 1'b0, 1'b0);
      step(5'b00001, 1'b0, 1'b0);
      hold(5'b10000, 1'b1, 10);
      hold(5'b00000, 1'b0, 10);
      r = '0;
      f = 1'b0;
      flip = 12;
      for (int i = 0; i < 2000; i++) begin
         if (i % 200 == 0) flip = $urandom_range(4, 40);
         for (int b = 0; b < 5; b++) begin
            if ($urandom_range(0, flip - 1) == 0) r[b] = ~r[b];
         end
         if ($urandom_range(0, 24) == 0) f = ~f;
         step(r, f, ($urandom_range(0, 699) != 0));
      end
      hold(5'b00000, 1'b0, 12);
      @(posedge clk);
      #2;
      done = 1;
      tests++;
      if (sb_q.size() != 0) begin
         failed++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
